cnn_layer_scheduler: RTL

CNN_LAYER_SCHEDULER -- requirements
Module: cnn_layer_scheduler

---
 rtl/cnn_layer_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cnn_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cnn_layer_scheduler
// Purpose  : Sequences an accelerator through N_LAYER layers over a simple
//            request/ack register bus. For each layer it writes the base
//            addresses and the layer configuration, pulses the start
//            register, then polls the done register until bit 0 is set.
//            The weight and parameter bases advance between layers.
// Ports    : HCLK, HRESETn          clock, synchronous active-low reset
//            tbl_we/tbl_idx/tbl_data layer-table write port
//                                    (data = {act_shift, bias_shift, is_conv3x3})
//            run, abort             start / abandon a sequence (pulses)
//            bus_req/bus_we/bus_addr/bus_wdata/bus_ack/bus_rdata
//                                    register-bus master
//            busy, done, cur_layer, error
//                                    status outputs
// Options  : SCHED_TIMEOUT_EN - when defined, 65535 consecutive not-done
//            polls within one layer set the sticky error flag and abandon
//            the sequence. When undefined, polling is unbounded and error
//            is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_layer_scheduler #(
  parameter int          N_LAYER    = 3,
  parameter int          TI         = 16,
  parameter int          TO         = 16,
  parameter int          N          = 16,
  parameter int          GAP        = 4,
  parameter int          POLL_GAP   = 128,
  parameter logic [31:0] ADDR_BASE  = 32'h4000_0000,
  parameter logic [31:0] ADDR_CFG   = 32'h4000_0004,
  parameter logic [31:0] ADDR_START = 32'h4000_0008,
  parameter logic [31:0] ADDR_DONE  = 32'h4000_000C
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        tbl_we,
  input  logic [3:0]  tbl_idx,
  input  logic [8:0]  tbl_data,
  input  logic        run,
  input  logic        abort,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic        done,
  output logic [3:0]  cur_layer,
  output logic        error
);

  // Shared idle counter is sized for the longer of the two wait periods.
  localparam int CNT_MAX = (GAP > POLL_GAP) ? GAP : POLL_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP > 0)      ? CNT_W'(GAP - 1)      : '0;
  localparam logic [CNT_W-1:0] POLL_LAST = (POLL_GAP > 0) ? CNT_W'(POLL_GAP - 1) : '0;

  localparam logic [19:0] W_STEP_3X3 = 20'(TI * TO * 9 / N);
  localparam logic [19:0] W_STEP_1X1 = 20'(TO);
  localparam logic [11:0] P_STEP     = 12'(TO);
  localparam logic [3:0]  LAST_IDX   = 4'(N_LAYER - 1);
  localparam logic [4:0]  N_LAYER_5  = 5'(N_LAYER);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_BASE   = 4'd1,
    WR_CFG    = 4'd2,
    WR_START1 = 4'd3,
    WR_START0 = 4'd4,
    POLL_WAIT = 4'd5,
    POLL_RD   = 4'd6,
    NEXT      = 4'd7,
    FIN       = 4'd8
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        idx, idx_nxt;
  logic [19:0]       weight_base, weight_base_nxt;
  logic [11:0]       param_base, param_base_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              req, req_nxt;
  logic              we, we_nxt;
  logic [31:0]       addr, addr_nxt;
  logic [31:0]       wdata, wdata_nxt;
  logic              busy_r, busy_nxt;
  logic              done_r, done_nxt;

  // Sixteen slots so the 4-bit index never needs truncation; only the
  // first N_LAYER are ever written.
  logic [8:0]        tbl [16];

  // Per-state transfer descriptor feeding the shared handshake logic.
  logic              xfer;
  logic              x_we;
  logic [31:0]       x_addr;
  logic [31:0]       x_data;
  state_t            x_next;

  logic              gap_done;
  logic              kill;
  logic [8:0]        entry;
  logic              is_first, is_last;
  logic [31:0]       cfg_word;

  // Only bit 0 of the read data carries the done status.
  logic              unused_rdata;
  assign unused_rdata = ^bus_rdata[31:1];

`ifdef SCHED_TIMEOUT_EN
  logic [15:0]       poll_cnt, poll_cnt_nxt;
  logic              error_r, error_nxt;
  logic              timeout_hit;
`endif

  assign entry    = tbl[idx];
  assign is_first = (idx == 4'd0);
  assign is_last  = (idx == LAST_IDX);
  assign cfg_word = {16'b0, entry[8:6], entry[5:1], idx, is_last, entry[0], is_last, is_first};
  assign gap_done = (GAP == 0) || (cnt == GAP_LAST);

  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    weight_base_nxt = weight_base;
    param_base_nxt  = param_base;
    cnt_nxt         = cnt;
    req_nxt         = req;
    we_nxt          = we;
    addr_nxt        = addr;
    wdata_nxt       = wdata;
    busy_nxt        = busy_r;
    done_nxt        = 1'b0;
    xfer            = 1'b0;
    x_we            = 1'b0;
    x_addr          = 32'h0;
    x_data          = 32'h0;
    x_next          = state;
    kill            = abort;
`ifdef SCHED_TIMEOUT_EN
    poll_cnt_nxt    = poll_cnt;
    error_nxt       = error_r;
    timeout_hit     = 1'b0;
`endif

    case (state)
      WR_BASE: begin
        xfer = 1'b1; x_we = 1'b1; x_addr = ADDR_BASE;
        x_data = {param_base, weight_base}; x_next = WR_CFG;
      end
      WR_CFG: begin
        xfer = 1'b1; x_we = 1'b1; x_addr = ADDR_CFG;
        x_data = cfg_word; x_next = WR_START1;
      end
      WR_START1: begin
        xfer = 1'b1; x_we = 1'b1; x_addr = ADDR_START;
        x_data = 32'h1; x_next = WR_START0;
      end
      WR_START0: begin
        xfer = 1'b1; x_we = 1'b1; x_addr = ADDR_START;
        x_data = 32'h0; x_next = POLL_WAIT;
      end
      POLL_RD: begin
        xfer = 1'b1; x_we = 1'b0; x_addr = ADDR_DONE;
        x_data = 32'h0; x_next = bus_rdata[0] ? NEXT : POLL_WAIT;
      end
      default: ;
    endcase

    case (state)
      IDLE: begin
        if (run) begin
          idx_nxt         = 4'd0;
          weight_base_nxt = 20'd0;
          param_base_nxt  = 12'd0;
          cnt_nxt         = '0;
          busy_nxt        = 1'b1;
          state_nxt       = WR_BASE;
`ifdef SCHED_TIMEOUT_EN
          poll_cnt_nxt    = 16'd0;
`endif
        end
      end
      POLL_WAIT: begin
        if ((POLL_GAP == 0) || (cnt == POLL_LAST)) begin
          cnt_nxt   = '0;
          state_nxt = POLL_RD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      NEXT: begin
        weight_base_nxt = weight_base + (entry[0] ? W_STEP_3X3 : W_STEP_1X1);
        param_base_nxt  = param_base + P_STEP;
        cnt_nxt         = '0;
`ifdef SCHED_TIMEOUT_EN
        poll_cnt_nxt    = 16'd0;
`endif
        if (idx < LAST_IDX) begin
          idx_nxt   = idx + 4'd1;
          state_nxt = WR_BASE;
        end else begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: ;
    endcase

    // Common handshake: idle GAP cycles, raise the request with address and
    // data frozen, and drop everything on the cycle the ack is seen.
    if (xfer) begin
      if (req) begin
        if (bus_ack) begin
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          addr_nxt  = 32'h0;
          wdata_nxt = 32'h0;
          cnt_nxt   = '0;
          state_nxt = x_next;
`ifdef SCHED_TIMEOUT_EN
          if (state == POLL_RD && !bus_rdata[0]) begin
            if (poll_cnt == 16'hFFFE) begin
              timeout_hit = 1'b1;
            end else begin
              poll_cnt_nxt = poll_cnt + 16'd1;
            end
          end
`endif
        end
      end else if (gap_done) begin
        req_nxt   = 1'b1;
        we_nxt    = x_we;
        addr_nxt  = x_addr;
        wdata_nxt = x_data;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end

`ifdef SCHED_TIMEOUT_EN
    if (timeout_hit) begin
      kill      = 1'b1;
      error_nxt = 1'b1;
    end
`endif

    // Abandon overrides every other decision, including a run in IDLE.
    if (kill) begin
      state_nxt = IDLE;
      req_nxt   = 1'b0;
      we_nxt    = 1'b0;
      addr_nxt  = 32'h0;
      wdata_nxt = 32'h0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state       <= IDLE;
      idx         <= 4'd0;
      weight_base <= 20'd0;
      param_base  <= 12'd0;
      cnt         <= '0;
      req         <= 1'b0;
      we          <= 1'b0;
      addr        <= 32'h0;
      wdata       <= 32'h0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      weight_base <= weight_base_nxt;
      param_base  <= param_base_nxt;
      cnt         <= cnt_nxt;
      req         <= req_nxt;
      we          <= we_nxt;
      addr        <= addr_nxt;
      wdata       <= wdata_nxt;
      busy_r      <= busy_nxt;
      done_r      <= done_nxt;
    end
  end

  // Table is frozen while a sequence runs; out-of-range indices are dropped.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < 16; i++) begin
        tbl[i] <= 9'd0;
      end
    end else if (tbl_we && !busy_r && ({1'b0, tbl_idx} < N_LAYER_5)) begin
      tbl[tbl_idx] <= tbl_data;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      poll_cnt <= 16'd0;
      error_r  <= 1'b0;
    end else begin
      poll_cnt <= poll_cnt_nxt;
      error_r  <= error_nxt;
    end
  end
  assign error = error_r;
`else
  assign error = 1'b0;
`endif

  assign bus_req   = req;
  assign bus_we    = we;
  assign bus_addr  = addr;
  assign bus_wdata = wdata;
  assign busy      = busy_r;
  assign done      = done_r;
  assign cur_layer = busy_r ? idx : 4'd0;

endmodule
`default_nettype wire
